ms_countdown_timer: RTL

//  Consumer of the 1 ms LFSR tick generator. Gates that generator's enable and counts
//  its ticks down from a loaded duration, then fires a one-cycle done pulse.

---
 rtl/ms_countdown_timer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ms_countdown_timer.sv
// ----------------------------------------------------------------------------
// ms_countdown_timer
//   Millisecond countdown built on top of the 1 ms tick generator. It gates the
//   generator's enable, counts rising edges of its tick output down from a
//   loaded duration, and fires a one-cycle done pulse on expiry. An optional
//   auto-reload restarts the count with the last loaded duration.
//
//   State table
//   state | meaning
//   IDLE  | not counting; remaining holds its last value
//   RUN   | generator enabled, tick edges decrement remaining
//   PAUSE | generator disabled, remaining frozen while pause is high
//
// Ports
//   clk        in   1      system clock, posedge
//   rst        in   1      synchronous active-high reset
//   start      in   1      load duration and run (any state)
//   cancel     in   1      abort without a done pulse
//   pause      in   1      level, freeze count while high
//   reload     in   1      level, sampled at expiry; 1 = auto-restart
//   duration   in   WIDTH  ms to count, sampled on the start cycle
//   tick1ms    in   1      tick generator output
//   tick_en    out  1      tick generator enable
//   busy       out  1      high in RUN or PAUSE
//   done       out  1      one-cycle expiry pulse
//   remaining  out  WIDTH  ms left
// ----------------------------------------------------------------------------
module ms_countdown_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic             pause,
    input  logic             reload,
    input  logic [WIDTH-1:0] duration,
    input  logic             tick1ms,
    output logic             tick_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_d;
    logic [WIDTH-1:0] dur_q, dur_d;
    logic [WIDTH-1:0] rem_d;
    logic             tick_q;
    logic             tk;
    logic             expire;
    logic             done_d;
    logic             busy_d;
    logic             tick_en_d;

    // The generator holds its output level while disabled, so only a fresh
    // rising edge seen in RUN counts as a tick.
    assign tk     = tick1ms & ~tick_q & (state == RUN);
    assign expire = tk & (remaining == ONE);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dur_q     <= '0;
            remaining <= '0;
            tick_q    <= 1'b1;
            done      <= 1'b0;
            busy      <= 1'b0;
            tick_en   <= 1'b0;
        end else begin
            state     <= state_d;
            dur_q     <= dur_d;
            remaining <= rem_d;
            tick_q    <= tick1ms;
            done      <= done_d;
            busy      <= busy_d;
            tick_en   <= tick_en_d;
        end
    end

    // Next-state logic, priority cancel > start > pause > tick
    always_comb begin
        state_d = state;
        if (cancel) begin
            state_d = IDLE;
        end else if (start) begin
            if (duration == '0)
                state_d = IDLE;
            else if (pause)
                state_d = PAUSE;
            else
                state_d = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (pause)
                        state_d = PAUSE;
                    else if (expire && !reload)
                        state_d = IDLE;
                end
                PAUSE: begin
                    if (!pause)
                        state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        dur_d  = dur_q;
        rem_d  = remaining;
        done_d = 1'b0;
        if (cancel) begin
            rem_d = remaining;
        end else if (start) begin
            dur_d  = duration;
            rem_d  = duration;
            done_d = (duration == '0);
        end else if (state == RUN && !pause && tk) begin
            // RUN always holds remaining >= 1, so this never wraps.
            if (remaining == ONE) begin
                done_d = 1'b1;
                rem_d  = reload ? dur_q : '0;
            end else begin
                rem_d = remaining - ONE;
            end
        end
        busy_d    = (state_d != IDLE);
        tick_en_d = (state_d == RUN);
    end

endmodule
